bitlet_unpack: RTL and testbench

//  Consumer end of the Bitlet packager index stream: receives MSB-first bit-index beats
//  (cnt/zero as produced by the MSB locator) with valid/ready handshake and rebuilds the

---
 rtl/bitlet_unpack.sv | 119 +++++++++++
 tb/tb_bitlet_unpack.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitlet_unpack.sv
// Rebuilds a W-bit word from an MSB-first stream of set-bit index beats.
// Define BITLET_UNPACK_ORDER_CHK_EN to enable the sticky ordering error flag.
module bitlet_unpack #(
  parameter int W = 64,
  localparam int N = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_cnt,
  input  logic         in_zero,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [N:0]   out_nbits,
  output logic         err
);

  typedef enum logic {
    ACC,
    FULL
  } state_t;

  state_t       state;
  logic [W-1:0] acc;
  logic [N:0]   acc_nbits;
  logic [W-1:0] mask;
  logic [W-1:0] word;
  logic [N:0]   word_nbits;
  logic [N:0]   inc;
  logic         fire;
  logic         term;
  logic         hit;
  logic         drain;

  assign out_valid = (state == FULL);
  assign in_ready  = ~out_valid | out_ready;
  assign fire      = in_valid & in_ready;
  assign term      = in_zero | in_last;
  assign drain     = out_valid & out_ready;

  assign mask = W'(1) << in_cnt;
  assign hit  = |(acc & mask);
  assign inc  = {{N{1'b0}}, ~hit};

  // A zero beat closes the word with whatever is collected so far.
  always_comb begin
    word       = acc | mask;
    word_nbits = acc_nbits + inc;
    if (in_zero) begin
      word       = acc;
      word_nbits = acc_nbits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      acc_nbits <= '0;
      out_data  <= '0;
      out_nbits <= '0;
    end else begin
      unique case (1'b1)
        fire & term: begin
          state     <= FULL;
          out_data  <= word;
          out_nbits <= word_nbits;
          acc       <= '0;
          acc_nbits <= '0;
        end
        fire & ~term: begin
          acc       <= acc | mask;
          acc_nbits <= acc_nbits + inc;
        end
        default: ;
      endcase
      if (drain & ~(fire & term))
        state <= ACC;
    end
  end

`ifdef BITLET_UNPACK_ORDER_CHK_EN
  logic [N-1:0] prev;
  logic         has_prev;
  logic         bad;
  logic         err_q;

  assign bad = fire & (
      (~in_zero & has_prev & (in_cnt >= prev))
    | (in_zero & (|acc)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      has_prev <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (bad)
        err_q <= 1'b1;
      if (fire) begin
        if (term) begin
          has_prev <= 1'b0;
        end else begin
          has_prev <= 1'b1;
          prev     <= in_cnt;
        end
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bitlet_unpack.sv
// Scoreboard bench for bitlet_unpack: driver queues expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_bitlet_unpack;

  localparam int W = 64;
  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_cnt;
  logic         in_zero;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [N:0]   out_nbits;
  logic         err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_data[$];
  logic [N:0]   exp_nbits[$];

`ifdef BITLET_UNPACK_ORDER_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  bitlet_unpack #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cnt    (in_cnt),
    .in_zero   (in_zero),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nbits (out_nbits),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_word(input logic [W-1:0] d,
                             input logic [N:0] n);
    exp_data.push_back(d);
    exp_nbits.push_back(n);
  endtask

  // Holds the beat until accepted; returns 1ns after the accepting edge.
  task automatic send(input int cnt, input bit z, input bit l);
    int guard;
    in_valid = 1'b1;
    in_cnt   = N'(cnt);
    in_zero  = z;
    in_last  = l;
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 200) begin
        chk("send_timeout", 64'(guard), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_zero  = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_data.size() == 0) begin
        chk("unexpected_word", out_data, 64'hDEAD);
      end else begin
        chk("out_data", out_data, exp_data.pop_front());
        chk("out_nbits", 64'(out_nbits), 64'(exp_nbits.pop_front()));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cnt    = '0;
    in_zero   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_nbits", 64'(out_nbits), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    idle(2);

    // T1: 7,5,2,0(last)
    expect_word(64'hA5, 7'd4);
    send(7, 0, 0);
    send(5, 0, 0);
    send(2, 0, 0);
    chk("t1_not_early", 64'(out_valid), 64'd0);
    send(0, 0, 1);
    chk("t1_latency", 64'(out_valid), 64'd1);
    idle(2);

    // T2: lone zero beat
    expect_word(64'h0, 7'd0);
    send(0, 1, 0);
    chk("t2_valid", 64'(out_valid), 64'd1);
    idle(2);

    // T3: top bit, then backpressure
    out_ready = 1'b0;
    expect_word(64'h8000_0000_0000_0000, 7'd1);
    send(63, 0, 1);
    chk("t3_valid", 64'(out_valid), 64'd1);
    expect_word(64'h4, 7'd1);
    fork
      send(2, 0, 1);
    join_none
    repeat (3) begin
      @(negedge clk);
      chk("t3_in_ready", 64'(in_ready), 64'd0);
      chk("t3_hold", out_data, 64'h8000_0000_0000_0000);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait fork;
    chk("t3_resume", out_data, 64'h4);
    idle(2);

    // T4: back-to-back single-beat words
    expect_word(64'h8, 7'd1);
    expect_word(64'h2, 7'd1);
    send(3, 0, 1);
    chk("t4_first", out_data, 64'h8);
    send(1, 0, 1);
    chk("t4_valid", 64'(out_valid), 64'd1);
    chk("t4_second", out_data, 64'h2);
    idle(2);

    // Full word: nbits reaches W
    expect_word({W{1'b1}}, 7'd64);
    for (int i = 63; i > 0; i--)
      send(i, 0, 0);
    send(0, 0, 1);
    idle(2);

    // T5: ascending order
    expect_word(64'h28, 7'd2);
    send(3, 0, 0);
    send(5, 0, 1);
    idle(1);
    chk("t5_err", 64'(err), 64'(ERR_EXP));
    idle(3);
    chk("t5_err_sticky", 64'(err), 64'(ERR_EXP));

    // Zero beat after a set bit ignores in_cnt/in_last
    expect_word(64'h40, 7'd1);
    send(6, 0, 0);
    send(5, 1, 1);
    idle(2);

    // T6: reset drops a partial word
    send(10, 0, 0);
    send(4, 0, 0);
    idle(1);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("t6_err", 64'(err), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    expect_word(64'h2, 7'd1);
    send(1, 0, 1);
    idle(2);

    // Duplicate index counted once
    expect_word(64'h200, 7'd1);
    send(9, 0, 0);
    send(9, 0, 0);
    send(9, 0, 1);
    idle(4);

    chk("queue_drained", 64'(exp_data.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
